alu_sequencial: RTL
===================

// Module: alu_sequencial
// PURPOSE
//  Multi-cycle ALU directly upstream of the accumulator: combines the accumulator value with a second operand.
//  Drives the accumulator write port: alu_result -> acc_in, alu_done -> acc_wr.
//  Single-cycle logic/arith ops; shifts iterate one bit per cycle; MUL is iterative shift-add.
//  Start/busy/done handshake with the control unit; status flags for branch decisions.
// PARAMETERS
//  DATA_WIDTH  11  operand/result width (matches accumulator word)
// PORTS
//  clock       in   1           single clock, all state updates on rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  alu_start   in   1           request; sampled on rising edge when state is IDLE or DONE
//  alu_op      in   4           opcode, latched with alu_start
//  alu_a       in   DATA_WIDTH  operand A (accumulator output), latched with alu_start
//  alu_b       in   DATA_WIDTH  operand B / shift amount, latched with alu_start
//  alu_result  out  DATA_WIDTH  registered result, stable from done until next accepted start
//  alu_done    out  1           one-cycle pulse, result and flags valid (acc write enable)
//  alu_busy    out  1           high in EXEC/SHIFT/MUL
//  alu_zero    out  1           result == 0
//  alu_neg     out  1           result[DATA_WIDTH-1]
//  alu_carry   out  1           ADD carry-out; SUB borrow (A<B unsigned); shifts: last bit shifted out; else 0
//  alu_ovf     out  1           ADD/SUB signed overflow; MUL upper product half nonzero; else 0
//  alu_illegal out  1           pulses with alu_done on reserved opcode
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B, 7 SLL, 8 SRL, 9 SRA, A MUL (unsigned), B-F reserved.
//  Reserved: result = A, flags from A, carry/ovf 0, alu_illegal=1 with done, latency as single-cycle.
//  FSM IDLE -> EXEC (ops 0-6, reserved) | SHIFT (7-9) | MUL (A) -> DONE -> IDLE.
//  Accepted start at edge k: done high in the cycle after edge k+1+n.
//    n=0 single-cycle; n=min(alu_b[3:0],DATA_WIDTH) shifts; n=DATA_WIDTH MUL.
//  SHIFT: one-bit shift and counter decrement per edge; exits to DONE at count 0 (n=0: result=A, carry=0).
//  SRA fills with the sign bit; SLL/SRL fill with 0.
//  MUL: shift-add over a 2*DATA_WIDTH product. Result = low half; ovf = |high half.
//  Result/flag registers load only on the edge entering DONE; hold otherwise.
//  DONE lasts exactly one cycle; alu_busy=0 in DONE.
//  Start in DONE is accepted (back-to-back, no bubble); start while busy is ignored (no queueing).
//  Inputs are don't-care after latching; changing alu_a/alu_b mid-op does not affect the result.
//  Async reset (reset_n=0) at any time: state IDLE; all outputs, internal operand, counter and product regs 0 immediately.
//    An in-flight op is aborted with no done pulse.
//  Reset release: IDLE; first start is accepted on the first rising edge with reset_n=1.
// TESTING (DATA_WIDTH=11)
//  ADD A=50,B=1000, start at edge k -> done after edge k+1, result=1050, neg=1, ovf=1, carry=0, zero=0.
//  SUB A=5,B=7 -> result=2046, carry=1, neg=1, ovf=0; SUB A=7,B=7 -> result=0, zero=1.
//  SRA A=11'b10110010010,B=3 -> busy 4 cycles, done after edge k+4, result=11'b11110110010, carry=0.
//    SLL with B=0 -> result=A, done after edge k+1.
//  MUL 45*45 -> done after edge k+12, result=2025, ovf=0; 50*50 -> result=452, ovf=1.
//    Start pulses during busy ignored.
//  Back-to-back: start held high -> ADD, then start accepted in DONE -> second done 2 cycles later.
//    Reserved op 4'hC, A=3 -> result=3, illegal=1.
//  Reset_n low 5 cycles into MUL -> all outputs 0 without waiting for a clock edge, no done.
//    After release, ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_sequencial.sv
// rtl/alu_sequencial.sv - multi-cycle ALU feeding the accumulator write port
module alu_sequencial #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alu_start,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_done,
  output logic                  alu_busy,
  output logic                  alu_zero,
  output logic                  alu_neg,
  output logic                  alu_carry,
  output logic                  alu_ovf,
  output logic                  alu_illegal
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic             sh_carry_q, sh_carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic             load;
  logic [W-1:0]     res_v;
  logic             carry_v, ovf_v, ill_v;
  logic [W:0]       ext;
  logic [CW-1:0]    amt_sat;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    sh_carry_d = sh_carry_q;
    result_d   = result_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    load       = 1'b0;
    res_v      = '0;
    carry_v    = 1'b0;
    ovf_v      = 1'b0;
    ill_v      = 1'b0;
    ext        = '0;
    amt_sat    = (int'(alu_b[3:0]) > W) ? CW'(W) : CW'(alu_b[3:0]);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (alu_start) begin
          op_d       = alu_op;
          a_d        = alu_a;
          b_d        = alu_b;
          sh_carry_d = 1'b0;
          prod_d     = '0;
          mcand_d    = {{W{1'b0}}, alu_a};
          cnt_d      = '0;
          if (alu_op == 4'h7 || alu_op == 4'h8 || alu_op == 4'h9) begin
            cnt_d   = amt_sat;
            state_d = S_SHIFT;
          end else if (alu_op == 4'hA) begin
            cnt_d   = CW'(W);
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        load = 1'b1;
        case (op_q)
          4'h0: begin
            ext     = {1'b0, a_q} + {1'b0, b_q};
            res_v   = ext[W-1:0];
            carry_v = ext[W];
            ovf_v   = (a_q[W-1] == b_q[W-1]) && (res_v[W-1] != a_q[W-1]);
          end
          4'h1: begin
            // Top bit of the widened difference is the unsigned borrow.
            ext     = {1'b0, a_q} - {1'b0, b_q};
            res_v   = ext[W-1:0];
            carry_v = ext[W];
            ovf_v   = (a_q[W-1] != b_q[W-1]) && (res_v[W-1] != a_q[W-1]);
          end
          4'h2: res_v = a_q & b_q;
          4'h3: res_v = a_q | b_q;
          4'h4: res_v = a_q ^ b_q;
          4'h5: res_v = ~a_q;
          4'h6: res_v = b_q;
          default: begin
            res_v = a_q;
            ill_v = 1'b1;
          end
        endcase
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          load    = 1'b1;
          res_v   = a_q;
          carry_v = sh_carry_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
          case (op_q)
            4'h7: begin
              sh_carry_d = a_q[W-1];
              a_d        = {a_q[W-2:0], 1'b0};
            end
            4'h8: begin
              sh_carry_d = a_q[0];
              a_d        = {1'b0, a_q[W-1:1]};
            end
            default: begin
              sh_carry_d = a_q[0];
              a_d        = {a_q[W-1], a_q[W-1:1]};
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          load  = 1'b1;
          res_v = prod_q[W-1:0];
          ovf_v = |prod_q[2*W-1:W];
        end else begin
          if (b_q[0]) prod_d = prod_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d   = S_DONE;
      result_d  = res_v;
      zero_d    = (res_v == '0);
      neg_d     = res_v[W-1];
      carry_d   = carry_v;
      ovf_d     = ovf_v;
      illegal_d = ill_v;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      sh_carry_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      sh_carry_q <= sh_carry_d;
      result_q   <= result_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_result  = result_q;
  assign alu_done    = done_q;
  assign alu_busy    = (state_q == S_EXEC) || (state_q == S_SHIFT) || (state_q == S_MUL);
  assign alu_zero    = zero_q;
  assign alu_neg     = neg_q;
  assign alu_carry   = carry_q;
  assign alu_ovf     = ovf_q;
  assign alu_illegal = illegal_q;

endmodule
